// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
// State encodings live here so the top and any tooling agree.
package mem_arbiter_pkg;

  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_D = 2'd1,
    GRANT_I = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: data port wins unless fetch is starving.
// One bus transaction at a time, always separated by an idle cycle.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ready,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              if_done,
  output logic              mem_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  arb_state_e        state_q, state_d;
  logic [CW-1:0]     starve_q, starve_d;
  logic              armed_q;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              gnt_d, gnt_i;

  // armed_q keeps the first edge after reset release grant-free
  assign gnt_d = armed_q & mem_req
               & (~if_req | (starve_q < LIM));
  assign gnt_i = armed_q & if_req & ~gnt_d;

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          gnt_d: begin
            state_d = GRANT_D;
            we_d    = mem_we;
            addr_d  = mem_addr;
            wdata_d = mem_wdata;
            if (if_req) starve_d = starve_q + CW'(1);
          end
          gnt_i: begin
            state_d  = GRANT_I;
            we_d     = 1'b0;
            addr_d   = if_addr;
            wdata_d  = '0;
            starve_d = '0;
          end
          default: ;
        endcase
      end
      GRANT_D: begin
        if (bus_ready) begin
          state_d = IDLE;
          if (!we_q) mem_rdata_d = bus_rdata;
        end
      end
      GRANT_I: begin
        if (bus_ready) begin
          state_d    = IDLE;
          if_rdata_d = bus_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      armed_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      armed_q     <= 1'b1;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign bus_req   = (state_q != IDLE);
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;

  assign if_done  = (state_q == GRANT_I) & bus_ready;
  assign mem_done = (state_q == GRANT_D) & bus_ready;

  // completion data is visible in the done cycle, then held
  assign if_rdata  = if_done ? bus_rdata : if_rdata_q;
  assign mem_rdata = (mem_done & ~we_q) ? bus_rdata : mem_rdata_q;

  assign stall_if  = if_req & ~if_done;
  assign stall_mem = mem_req & ~mem_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed + randomized bench for mem_arbiter against a
// transaction-level reference model.
module tb_mem_arbiter;

  localparam int LIMIT = 4;
  localparam int NONE  = 0;
  localparam int DATA  = 1;
  localparam int FETCH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic        bus_req, bus_we, bus_ready;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        if_done, mem_done, stall_if, stall_mem;
  logic [31:0] if_rdata, mem_rdata;

  int tests = 0;
  int fails = 0;

  // reference model: who owns the bus and what it latched
  int          owner;
  int          m_starve;
  bit          m_armed;
  bit          m_we;
  logic [31:0] m_addr, m_wdata, m_ifr, m_memr;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .if_done(if_done), .mem_done(mem_done),
    .if_rdata(if_rdata), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner = NONE; m_starve = 0; m_armed = 0;
    m_we = 0; m_addr = '0; m_wdata = '0;
    m_ifr = '0; m_memr = '0;
  endtask

  task automatic check_outputs();
    bit idn, mdn;
    logic [31:0] eir, emr;
    idn = (owner == FETCH) && bus_ready;
    mdn = (owner == DATA) && bus_ready;
    eir = idn ? bus_rdata : m_ifr;
    emr = (mdn && !m_we) ? bus_rdata : m_memr;
    chk("bus_req", 32'(bus_req), 32'(owner != NONE));
    if (owner != NONE) begin
      chk("bus_addr", bus_addr, m_addr);
      chk("bus_we", 32'(bus_we), 32'(m_we));
    end
    if (owner == DATA) chk("bus_wdata", bus_wdata, m_wdata);
    chk("if_done", 32'(if_done), 32'(idn));
    chk("mem_done", 32'(mem_done), 32'(mdn));
    chk("if_rdata", if_rdata, eir);
    chk("mem_rdata", mem_rdata, emr);
    chk("stall_if", 32'(stall_if), 32'(if_req && !idn));
    chk("stall_mem", 32'(stall_mem), 32'(mem_req && !mdn));
  endtask

  task automatic model_update();
    if (owner != NONE) begin
      if (bus_ready) begin
        if (owner == FETCH) m_ifr = bus_rdata;
        if (owner == DATA && !m_we) m_memr = bus_rdata;
        owner = NONE;
      end
    end else if (!m_armed) begin
      m_armed = 1;
    end else if (mem_req && (!if_req || m_starve < LIMIT)) begin
      owner = DATA; m_addr = mem_addr;
      m_we = mem_we; m_wdata = mem_wdata;
      if (if_req) m_starve++;
    end else if (if_req) begin
      owner = FETCH; m_addr = if_addr;
      m_we = 0; m_starve = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // wait for a grant, hold it lat cycles, then complete it
  task automatic serve(input int lat, output logic [31:0] gaddr,
                       output logic gwe, output logic [31:0] rd);
    int n = 0;
    bus_ready = 0;
    gaddr = 'x; gwe = 'x; rd = $urandom;
    while (!bus_req && n < 20) begin step(); n++; end
    if (!bus_req) begin
      chk("grant_timeout", 32'(bus_req), 32'd1);
      return;
    end
    gaddr = bus_addr; gwe = bus_we;
    repeat (lat) step();
    bus_ready = 1; bus_rdata = rd;
    step();
    bus_ready = 0;
  endtask

  task automatic check_reset_vals(string t);
    chk({t, "_bus_req"}, 32'(bus_req), 32'd0);
    chk({t, "_bus_we"}, 32'(bus_we), 32'd0);
    chk({t, "_bus_addr"}, bus_addr, 32'd0);
    chk({t, "_bus_wdata"}, bus_wdata, 32'd0);
    chk({t, "_if_rdata"}, if_rdata, 32'd0);
    chk({t, "_mem_rdata"}, mem_rdata, 32'd0);
  endtask

  // async reset mid-cycle, held across one edge, released post-edge
  task automatic do_reset();
    #3 rst_n = 0;
    #1;
    chk("rst_if_done", 32'(if_done), 32'd0);
    chk("rst_mem_done", 32'(mem_done), 32'd0);
    check_reset_vals("rst");
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  logic [31:0] ga, rd, prev;
  logic        gw;
  int          n;
  string       seq, exp_seq;

  initial begin
    rst_n = 0; if_req = 0; mem_req = 0; mem_we = 0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0;
    bus_ready = 0; bus_rdata = '0;
    model_reset();
    #2;
    check_reset_vals("por");
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // ready in idle with no requests is ignored
    bus_ready = 1; bus_rdata = 32'h1234_5678;
    repeat (3) step();
    bus_ready = 0;
    chk("idle_ready_if_rdata", if_rdata, 32'd0);

    // single fetch, ready 3 cycles after bus_req
    if_req = 1; if_addr = 32'h40;
    serve(3, ga, gw, rd);
    chk("fetch_addr", ga, 32'h40);
    chk("fetch_we", 32'(gw), 32'd0);
    chk("fetch_rdata_now", if_rdata, rd);
    if_req = 0;
    step();
    chk("fetch_rdata_held", if_rdata, rd);

    // simultaneous requests: data first, then fetch
    if_req = 1; if_addr = 32'h80;
    mem_req = 1; mem_we = 0; mem_addr = 32'h200;
    serve(1, ga, gw, rd);
    chk("both_first_addr", ga, 32'h200);
    mem_req = 0;
    step();
    chk("both_gap_idle", 32'(bus_req), 32'd1);
    serve(0, ga, gw, rd);
    chk("both_second_addr", ga, 32'h80);
    if_req = 0;
    step();

    // starvation limit: four data grants then fetch
    do_reset();
    if_req = 1; if_addr = 32'h1000;
    mem_req = 1; mem_addr = 32'h2000; mem_we = 0;
    seq = ""; exp_seq = "DDDDI";
    for (int i = 0; i < 5; i++) begin
      serve(0, ga, gw, rd);
      seq = {seq, (ga == 32'h1000) ? "I" : "D"};
    end
    tests++;
    assert (seq == exp_seq) else begin
      fails++;
      $error("FAIL starve_seq: observed %s expected %s", seq, exp_seq);
    end
    mem_req = 0; if_req = 0;
    step();

    // store returns mem_rdata unchanged
    prev = m_memr;
    mem_req = 1; mem_we = 1;
    mem_addr = 32'h100; mem_wdata = 32'hDEAD_BEEF;
    n = 0;
    while (!bus_req && n < 5) begin step(); n++; end
    chk("store_we", 32'(bus_we), 32'd1);
    chk("store_wdata", bus_wdata, 32'hDEAD_BEEF);
    chk("store_addr", bus_addr, 32'h100);
    bus_ready = 1; bus_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("store_done", 32'(mem_done), 32'd1);
    chk("store_rdata", mem_rdata, prev);
    @(posedge clk); model_update(); #1;
    bus_ready = 0; mem_req = 0; mem_we = 0;
    step();

    // reset during a fetch grant
    if_req = 1; if_addr = 32'h3C;
    n = 0;
    while (!bus_req && n < 5) begin step(); n++; end
    chk("pre_rst_grant", 32'(bus_req), 32'd1);
    bus_ready = 1; bus_rdata = 32'h5555_AAAA;
    do_reset();
    bus_ready = 0;
    step();
    step();
    serve(0, ga, gw, rd);
    chk("post_rst_fetch", ga, 32'h3C);
    if_req = 0;
    step();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if_req    = ($urandom_range(0, 9) < 6);
      mem_req   = ($urandom_range(0, 9) < 6);
      mem_we    = $urandom_range(0, 1);
      if_addr   = $urandom;
      mem_addr  = $urandom;
      mem_wdata = $urandom;
      bus_ready = ($urandom_range(0, 9) < 4);
      bus_rdata = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum number of consecutive data grants while fetch waits.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-006 SHALL have ports if_req (in, 1, fetch request) and if_addr (in, ADDR_W, fetch address).
REQ-007 SHALL have ports mem_req, mem_we (in, 1 each, data request and write flag), mem_addr (in, ADDR_W) and mem_wdata (in, DATA_W).
REQ-008 SHALL have ports bus_req, bus_we (out, 1 each), bus_addr (out, ADDR_W) and bus_wdata (out, DATA_W): the shared memory port.
REQ-009 SHALL have ports bus_ready (in, 1, transaction-complete pulse) and bus_rdata (in, DATA_W).
REQ-010 SHALL have ports if_done and mem_done (out, 1 each, completion strobes) and if_rdata and mem_rdata (out, DATA_W each).
REQ-011 SHALL have ports stall_if and stall_mem (out, 1 each): pipeline stall requests to the hazard logic.

Function
REQ-012 SHALL implement FSM states IDLE, GRANT_D and GRANT_I.
REQ-013 In IDLE, SHALL go to GRANT_D if mem_req and (!if_req or starve_cnt < STARVE_LIMIT); else to GRANT_I if if_req; else stay in IDLE.
REQ-014 On any transition out of IDLE, SHALL latch the granted requester's addr, we and wdata into the bus_* registers; bus_we SHALL be 0 for fetch.
REQ-015 In GRANT_D and GRANT_I, SHALL assert bus_req and hold the bus_* values constant until bus_ready.
REQ-016 Latency: a request seen in IDLE at cycle N SHALL give bus_req=1 at cycle N+1.
REQ-017 if_done SHALL be (state==GRANT_I & bus_ready) and mem_done SHALL be (state==GRANT_D & bus_ready), both combinational and one cycle wide.
REQ-018 On completion, bus_rdata SHALL be passed to the granted *_rdata in the same cycle and held in a register until that requester's next completion.
REQ-019 On bus_ready, SHALL return to IDLE, so there is at least one idle cycle between transactions and no re-grant to a requester still holding req in its done cycle.
REQ-020 bus_ready while in IDLE SHALL be ignored.
REQ-021 stall_if SHALL equal if_req & !if_done; stall_mem SHALL equal mem_req & !mem_done.
REQ-022 starve_cnt (width clog2(STARVE_LIMIT+1)) SHALL increment on each IDLE->GRANT_D taken while if_req=1.
REQ-023 starve_cnt SHALL clear on IDLE->GRANT_I and SHALL saturate at STARVE_LIMIT.
REQ-024 If a requester deasserts req mid-grant, the bus transaction SHALL still complete and done SHALL still pulse.
REQ-025 The store (mem_we=1) SHALL return mem_rdata unchanged.

Reset
REQ-026 rst_n low SHALL force, without waiting for clk: state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, starve_cnt=0, if_rdata=0, mem_rdata=0.
REQ-027 Reset mid-transaction SHALL abandon the transaction with no done pulse.
REQ-028 The first grant after rst_n rises SHALL be at the earliest on the second clk edge.

Structure
REQ-029 State encodings and the STARVE_LIMIT default SHALL live in the shared defines file.
REQ-030 The design SHALL be a single module with no sub-module; the starvation counter SHALL be inline.

Verification
REQ-031 Test: single fetch, if_addr=0x40, bus_ready 3 cycles after bus_req -> bus_addr=0x40, bus_we=0, if_done for 1 cycle, if_rdata=bus_rdata, stall_if=0 after done.
REQ-032 Test: if_req and mem_req raised together, starve_cnt=0 -> GRANT_D first, then GRANT_I after one IDLE cycle; stall_if=1 throughout the data transaction.
REQ-033 Test: mem_req re-raised continuously with if_req held, STARVE_LIMIT=4 -> exactly 4 data grants, then the 5th grant is GRANT_I.
REQ-034 Test: store of 0xDEADBEEF to 0x100 -> bus_we=1, bus_wdata=0xDEADBEEF, mem_done pulses, mem_rdata unchanged.
REQ-035 Test: rst_n low during GRANT_I -> bus_req=0 immediately (asynchronously), no if_done, IDLE after release.
REQ-036 Test: bus_ready pulsed in IDLE with no requests -> no done, no state change.
